manchester_tx_sched: RTL

- Round-robin scheduler that shares one manchester_TX serializer among NUM_REQ byte requesters.
- Captures the winning requester's byte and issues a single-cycle trmt pulse to the serializer.
- Waits for the serializer's done, enforces an inter-frame gap, and reports per-requester completion or timeout.
- Sits between board-level sources (switch/key logic, test pattern generators) and the manchester_TX instance.

---
 rtl/manchester_pkg.sv | 15 +
 rtl/rr_pick.sv | 28 ++
 rtl/manchester_tx_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared types and default constants for the manchester_TX request scheduler.
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int unsigned MANCH_DATA_W    = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;
  localparam int unsigned DEF_GAP_CYC     = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Farthest offset first, so the request nearest to ptr overwrites last.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + (NUM_REQ - 1 - k)) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/manchester_tx_sched.sv
// Shares one manchester_TX serializer among NUM_REQ byte requesters (round robin),
// with done blanking, frame timeout and a forced inter-frame gap.
module manchester_tx_sched
  import manchester_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = MANCH_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        sent,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      trmt,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GCNT_W = $clog2(GAP_CYC + 1);

  sched_state_t        state, state_d;
  logic [IDX_W-1:0]    ptr, ptr_d;
  logic [IDX_W-1:0]    owner, owner_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic [GCNT_W-1:0]   gcnt, gcnt_d;
  logic [DATA_W-1:0]   tx_data_d;
  logic [NUM_REQ-1:0]  gnt_d, sent_d, err_d;
  logic                trmt_d, busy_d;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      tcnt    <= '0;
      gcnt    <= '0;
      tx_data <= '0;
      gnt     <= '0;
      sent    <= '0;
      err     <= '0;
      trmt    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      tcnt    <= tcnt_d;
      gcnt    <= gcnt_d;
      tx_data <= tx_data_d;
      gnt     <= gnt_d;
      sent    <= sent_d;
      err     <= err_d;
      trmt    <= trmt_d;
      busy    <= busy_d;
    end
  end

  // Outputs are computed one state ahead so that every port is a flop.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    owner_d   = owner;
    tcnt_d    = tcnt;
    gcnt_d    = gcnt;
    tx_data_d = tx_data;
    gnt_d     = '0;
    sent_d    = '0;
    err_d     = '0;
    trmt_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d         = LAUNCH;
          owner_d         = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          trmt_d          = 1'b1;
          ptr_d           = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) tx_data_d = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        tcnt_d  = '0;
      end
      WAIT_DONE: begin
        tcnt_d = tcnt + 1'b1;
        // tcnt==0 blanks a done level left over from the previous frame.
        if (tx_done && (tcnt != '0)) begin
          sent_d[owner] = 1'b1;
          state_d       = GAP;
          gcnt_d        = '0;
        end else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
          err_d[owner] = 1'b1;
          state_d      = GAP;
          gcnt_d       = '0;
        end
      end
      GAP: begin
        if (gcnt == GCNT_W'(GAP_CYC - 1)) state_d = IDLE;
        else                              gcnt_d  = gcnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
